spi_flash_sequencer: RTL and testbench

//  Shares one 32-bit SPI word engine (spi master + CS/SCK driver) between two bus requesters.

---
 rtl/spi_flash_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_spi_flash_sequencer.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer
// Shares one 32-bit SPI word engine between two requesters with round-robin arbitration and
// expands each granted request into flash command frames:
//   read : READ (03 + addr, CS held) then one 32-bit data frame
//   write: WREN (06), PAGE PROGRAM (02 + addr, CS held), data word, then RDSR (05) polling
//          separated by POLL_GAP idle cycles until WIP clears
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset (shared with the engine)
//   rN_req/we/addr/wdata       requester N (N = 0, 1); fields stable while req is high
//   rN_ack                     one-cycle completion pulse to requester N
//   rdata                      last read result, held until the next read completes
//   err                        high in the ack cycle of a write whose polling timed out
//   busy                       high whenever the sequencer is not idle
//   eng_en                     one-cycle frame start pulse to the engine
//   eng_din/eng_len/eng_hold   frame word (left-aligned), byte count - 1, keep CS low after frame;
//                              driven from the eng_en cycle until eng_done
//   eng_dout/eng_done          frame rx bytes (right-aligned) and completion pulse
//
// Build option: define SPI_SEQ_TIMEOUT_EN to bound RDSR polling to POLL_MAX frames per write;
// without it polling is unbounded and err is tied low.

module spi_flash_sequencer #(
  parameter int unsigned POLL_GAP = 8,
  parameter int unsigned POLL_MAX = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [23:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [23:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        eng_en,
  output logic [31:0] eng_din,
  output logic [1:0]  eng_len,
  output logic        eng_hold,
  input  logic [31:0] eng_dout,
  input  logic        eng_done
);

  // Both counters are 16 bits wide; reject configurations that cannot fit.
  if (POLL_GAP < 1 || POLL_GAP > 65535) begin : g_bad_poll_gap
    $error("POLL_GAP must be in 1..65535");
  end
  if (POLL_MAX < 1 || POLL_MAX > 65535) begin : g_bad_poll_max
    $error("POLL_MAX must be in 1..65535");
  end

  typedef enum logic [3:0] {
    StIdle,
    StRdCmd,
    StRdDat,
    StWren,
    StPpCmd,
    StPpDat,
    StGap,
    StPoll,
    StAck
  } state_e;

  localparam logic [15:0] GapLast = 16'(POLL_GAP - 1);

  state_e      state_q, state_d;
  logic        last_q;     // port granted most recently
  logic        gnt_q;      // port currently being served
  logic [23:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        sent_q;     // eng_en already issued in the current frame state
  logic [15:0] gap_q;

  logic        grant;
  logic        pick;
  logic        pick_we;
  logic        in_frame;
  logic        done_ok;
  logic        poll_last;  // this poll is the final one allowed before timeout

  // Round robin: with both requesting, serve the port not served last.
  assign grant   = (state_q == StIdle) & (r0_req | r1_req);
  assign pick    = (r0_req & r1_req) ? ~last_q : ~r0_req;
  assign pick_we = pick ? r1_we : r0_we;

  // eng_done only counts for a frame this block actually started.
  assign done_ok = eng_done & sent_q;

  always_comb begin
    state_d  = state_q;
    in_frame = 1'b0;
    eng_din  = '0;
    eng_len  = '0;
    eng_hold = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant) state_d = pick_we ? StWren : StRdCmd;
      end
      StRdCmd: begin
        in_frame = 1'b1;
        eng_din  = {8'h03, addr_q};
        eng_len  = 2'd3;
        eng_hold = 1'b1;
        if (done_ok) state_d = StRdDat;
      end
      StRdDat: begin
        in_frame = 1'b1;
        eng_len  = 2'd3;
        if (done_ok) state_d = StAck;
      end
      StWren: begin
        in_frame = 1'b1;
        eng_din  = {8'h06, 24'h0};
        if (done_ok) state_d = StPpCmd;
      end
      StPpCmd: begin
        in_frame = 1'b1;
        eng_din  = {8'h02, addr_q};
        eng_len  = 2'd3;
        eng_hold = 1'b1;
        if (done_ok) state_d = StPpDat;
      end
      StPpDat: begin
        in_frame = 1'b1;
        eng_din  = wdata_q;
        eng_len  = 2'd3;
        if (done_ok) state_d = StGap;
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StPoll;
      end
      StPoll: begin
        in_frame = 1'b1;
        eng_din  = {8'h05, 24'h0};
        eng_len  = 2'd1;
        if (done_ok) state_d = (eng_dout[0] && !poll_last) ? StGap : StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    eng_en = in_frame & ~sent_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sent_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        gnt_q   <= pick;
        last_q  <= pick;
        addr_q  <= pick ? r1_addr : r0_addr;
        wdata_q <= pick ? r1_wdata : r0_wdata;
      end
      // Every frame state is left on its eng_done, so a state change re-arms eng_en.
      sent_q <= (state_d != state_q) ? 1'b0 : (sent_q | eng_en);
      gap_q  <= (state_q == StGap) ? gap_q + 16'd1 : 16'd0;
      if (state_q == StRdDat && done_ok) rdata_q <= eng_dout;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [15:0] PollLast = 16'(POLL_MAX - 1);

  logic [15:0] poll_cnt_q;  // RDSR frames completed for the current write
  logic        err_q;

  assign poll_last = (poll_cnt_q == PollLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (grant) begin
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (state_q == StPoll && done_ok) begin
      poll_cnt_q <= poll_cnt_q + 16'd1;
      if (eng_dout[0] && poll_last) err_q <= 1'b1;
    end
  end

  assign err = (state_q == StAck) & err_q;
`else
  assign poll_last = 1'b0;
  assign err       = 1'b0;
`endif

  assign busy   = (state_q != StIdle);
  assign r0_ack = (state_q == StAck) & ~gnt_q;
  assign r1_ack = (state_q == StAck) & gnt_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_spi_flash_sequencer.sv
`timescale 1ns/1ps
module tb_spi_flash_sequencer;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int POLL_MAX = 4;
`else
  localparam int POLL_MAX = 50000;
`endif
  localparam int POLL_GAP   = 8;
  localparam int BFM_LAT    = 40;
  localparam int TXN_BUDGET = 4000;

  logic        clk, rst;
  logic        r0_req, r0_we, r0_ack, r1_req, r1_we, r1_ack;
  logic [23:0] r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata, rdata;
  logic        err, busy, eng_en, eng_hold, eng_done;
  logic [31:0] eng_din, eng_dout;
  logic [1:0]  eng_len;

  spi_flash_sequencer #(
    .POLL_GAP(POLL_GAP),
    .POLL_MAX(POLL_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack),
    .rdata(rdata), .err(err), .busy(busy),
    .eng_en(eng_en), .eng_din(eng_din), .eng_len(eng_len), .eng_hold(eng_hold),
    .eng_dout(eng_dout), .eng_done(eng_done)
  );

  typedef struct {
    logic [31:0] din;
    logic [1:0]  len;
    logic        hold;
    int          en_cyc;
    int          done_cyc;
  } frame_t;

  typedef struct {
    int          port;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } ack_t;

  frame_t      got_q[$];
  frame_t      exp_q[$];
  ack_t        ack_q[$];
  ack_t        exp_ack_q[$];
  logic        wip_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] model_rdata;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int overlap_cnt = 0;
  int hold_bad = 0;
  int req_cyc[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  // Engine BFM plus ack monitor; everything sampled at the falling edge.
  frame_t      bfm_cur;
  logic        bfm_pend = 1'b0;
  int          bfm_left = 0;
  logic [31:0] bfm_resp;
  logic [31:0] rnd;
  logic        wip;

  always @(negedge clk) begin
    eng_done <= 1'b0;
    if (rst) begin
      bfm_pend = 1'b0;
    end else begin
      if (eng_en && bfm_pend) overlap_cnt++;
      if (bfm_pend) begin
        if (eng_din !== bfm_cur.din || eng_len !== bfm_cur.len || eng_hold !== bfm_cur.hold)
          hold_bad++;
        bfm_left--;
        if (bfm_left == 0) begin
          if (got_q.size() > 0) got_q[got_q.size() - 1].done_cyc = cyc;
          eng_dout <= bfm_resp;
          eng_done <= 1'b1;
          bfm_pend = 1'b0;
        end
      end
      if (eng_en) begin
        bfm_cur = '{eng_din, eng_len, eng_hold, cyc, -1};
        got_q.push_back(bfm_cur);
        bfm_pend = 1'b1;
        bfm_left = BFM_LAT;
        rnd = $urandom;
        if (eng_din[31:24] == 8'h05 && eng_len == 2'd1) begin
          wip = (wip_q.size() > 0) ? wip_q.pop_front() : 1'b0;
          bfm_resp = {rnd[31:1], wip};
        end else if (eng_din == 32'h0 && eng_len == 2'd3 && !eng_hold) begin
          bfm_resp = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        end else begin
          bfm_resp = rnd;
        end
      end
      if (r0_ack) ack_q.push_back('{0, cyc, rdata, err});
      if (r1_ack) ack_q.push_back('{1, cyc, rdata, err});
    end
  end

  // Reference model: the frame list and ack each transaction must produce.
  function automatic void push_exp(input logic [31:0] din, input logic [1:0] len, input logic hold);
    exp_q.push_back('{din, len, hold, 0, 0});
  endfunction

  function automatic void model_read(input int port, input logic [23:0] a, input logic [31:0] d);
    push_exp({8'h03, a}, 2'd3, 1'b1);
    push_exp(32'h0, 2'd3, 1'b0);
    rd_q.push_back(d);
    model_rdata = d;
    exp_ack_q.push_back('{port, 0, d, 1'b0});
  endfunction

  // n_busy polls report WIP=1 before the one reporting WIP=0.
  function automatic void model_write(input int port, input logic [23:0] a, input logic [31:0] wd,
                                      input int n_busy);
    int   npoll = n_busy + 1;
    logic e = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    if (n_busy >= POLL_MAX) begin
      npoll = POLL_MAX;
      e = 1'b1;
    end
`endif
    push_exp({8'h06, 24'h0}, 2'd0, 1'b0);
    push_exp({8'h02, a}, 2'd3, 1'b1);
    push_exp(wd, 2'd3, 1'b0);
    for (int i = 0; i < npoll; i++) push_exp({8'h05, 24'h0}, 2'd1, 1'b0);
    for (int i = 0; i < n_busy; i++) wip_q.push_back(1'b1);
    wip_q.push_back(1'b0);
    exp_ack_q.push_back('{port, 0, model_rdata, e});
  endfunction

  // First index where observed and modelled frames differ, -1 if identical.
  function automatic int frame_diff();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i].din !== exp_q[i].din || got_q[i].len !== exp_q[i].len ||
          got_q[i].hold !== exp_q[i].hold) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int ack_diff();
    int n = (ack_q.size() < exp_ack_q.size()) ? ack_q.size() : exp_ack_q.size();
    for (int i = 0; i < n; i++)
      if (ack_q[i].port != exp_ack_q[i].port || ack_q[i].rdata !== exp_ack_q[i].rdata ||
          ack_q[i].err !== exp_ack_q[i].err) return i;
    if (ack_q.size() != exp_ack_q.size()) return n;
    return -1;
  endfunction

  // Acks that do not land exactly one cycle after some frame's eng_done.
  function automatic int ack_late_cnt();
    int bad = 0;
    for (int i = 0; i < ack_q.size(); i++) begin
      bit hit = 1'b0;
      foreach (got_q[j]) if (got_q[j].done_cyc == ack_q[i].cyc - 1) hit = 1'b1;
      if (!hit) bad++;
    end
    return bad;
  endfunction

  function automatic void show_frames(input string name, input int idx);
    if (idx < got_q.size() && idx < exp_q.size())
      $display("FAIL %s frame %0d: got din=%h len=%0d hold=%0b, expected din=%h len=%0d hold=%0b",
               name, idx, got_q[idx].din, got_q[idx].len, got_q[idx].hold,
               exp_q[idx].din, exp_q[idx].len, exp_q[idx].hold);
    else
      $display("FAIL %s frames: got %0d frames, expected %0d", name, got_q.size(), exp_q.size());
  endfunction

  function automatic void show_acks(input string name, input int idx);
    if (idx < ack_q.size() && idx < exp_ack_q.size())
      $display("FAIL %s ack %0d: got port=%0d rdata=%h err=%0b, expected port=%0d rdata=%h err=%0b",
               name, idx, ack_q[idx].port, ack_q[idx].rdata, ack_q[idx].err,
               exp_ack_q[idx].port, exp_ack_q[idx].rdata, exp_ack_q[idx].err);
    else
      $display("FAIL %s acks: got %0d acks, expected %0d", name, ack_q.size(), exp_ack_q.size());
  endfunction

  function automatic void clear_logs();
    got_q.delete();
    exp_q.delete();
    ack_q.delete();
    exp_ack_q.delete();
  endfunction

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    r0_req = 1'b0;
    r1_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wip_q.delete();
    rd_q.delete();
    model_rdata = 32'h0;
    clear_logs();
  endtask

  // Holds req until nacks acks have been seen, then drops it; bounded wait.
  task automatic drive_req(input int port, input logic we, input logic [23:0] a,
                           input logic [31:0] wd, input int nacks);
    int seen = 0;
    int waited = 0;
    @(posedge clk);
    #1;
    if (port == 0) begin
      r0_we = we; r0_addr = a; r0_wdata = wd; r0_req = 1'b1;
    end else begin
      r1_we = we; r1_addr = a; r1_wdata = wd; r1_req = 1'b1;
    end
    req_cyc[port] = cyc;
    while (seen < nacks && waited < TXN_BUDGET) begin
      @(negedge clk);
      waited++;
      if ((port == 0) ? r0_ack : r1_ack) seen++;
    end
    @(posedge clk);
    #1;
    if (port == 0) r0_req = 1'b0;
    else r1_req = 1'b0;
    n_chk++;
    if (seen != nacks) $display("FAIL req_wait port%0d: got %0d acks, expected %0d", port, seen, nacks);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({busy, eng_en, r0_ack, r1_ack, err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b, expected 00000", {busy, eng_en, r0_ack, r1_ack, err});
    else n_pass++;
    n_chk++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h, expected 00000000", rdata);
    else n_pass++;
    n_chk++;
    if ({eng_din, eng_len, eng_hold} !== 35'h0)
      $display("FAIL reset_frame: got din=%h len=%0d hold=%0b, expected zero", eng_din, eng_len, eng_hold);
    else n_pass++;
    reset_dut();
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || eng_en !== 1'b0)
      $display("FAIL idle_after_reset: got busy=%0b eng_en=%0b, expected 0 0", busy, eng_en);
    else n_pass++;
  endtask

  task automatic test_read();
    int d;
    clear_logs();
    model_read(0, 24'h000100, 32'hDEADBEEF);
    drive_req(0, 1'b0, 24'h000100, 32'h0, 1);
    d = frame_diff();
    n_chk++;
    if (d != -1) show_frames("read_frames", d); else n_pass++;
    d = ack_diff();
    n_chk++;
    if (d != -1) show_acks("read_ack", d); else n_pass++;
    n_chk++;
    if (got_q.size() < 1 || got_q[0].en_cyc != req_cyc[0] + 1)
      $display("FAIL read_latency: got eng_en cycle %0d, expected %0d",
               (got_q.size() > 0) ? got_q[0].en_cyc : -1, req_cyc[0] + 1);
    else n_pass++;
    n_chk++;
    if (ack_late_cnt() != 0) $display("FAIL read_ack_timing: got %0d late acks, expected 0", ack_late_cnt());
    else n_pass++;
  endtask

  task automatic test_write();
    int d;
    int gap_bad = 0;
    clear_logs();
    model_write(1, 24'h0000FF, 32'h12345678, 2);
    drive_req(1, 1'b1, 24'h0000FF, 32'h12345678, 1);
    d = frame_diff();
    n_chk++;
    if (d != -1) show_frames("write_frames", d); else n_pass++;
    d = ack_diff();
    n_chk++;
    if (d != -1) show_acks("write_ack", d); else n_pass++;
    for (int i = 3; i < got_q.size(); i++)
      if (got_q[i].en_cyc - got_q[i - 1].done_cyc - 1 < POLL_GAP) gap_bad++;
    n_chk++;
    if (gap_bad != 0) $display("FAIL poll_gap: got %0d short gaps, expected 0", gap_bad);
    else n_pass++;
    n_chk++;
    if (ack_late_cnt() != 0) $display("FAIL write_ack_timing: got %0d late acks, expected 0", ack_late_cnt());
    else n_pass++;
  endtask

  task automatic test_arbitration();
    int d;
    logic [23:0] a0, a1;
    reset_dut();
    for (int rnd_i = 0; rnd_i < 2; rnd_i++) begin
      clear_logs();
      a0 = 24'($urandom);
      a1 = 24'($urandom);
      model_read(0, a0, $urandom);
      model_read(1, a1, $urandom);
      fork
        drive_req(0, 1'b0, a0, 32'h0, 1);
        drive_req(1, 1'b0, a1, 32'h0, 1);
      join
      d = frame_diff();
      n_chk++;
      if (d != -1) show_frames("arb_frames", d); else n_pass++;
      d = ack_diff();
      n_chk++;
      if (d != -1) show_acks("arb_order", d); else n_pass++;
      n_chk++;
      if (got_q.size() < 3 || ack_q.size() < 1 || got_q[2].en_cyc != ack_q[0].cyc + 2)
        $display("FAIL arb_regrant round%0d: got second eng_en at %0d, expected %0d", rnd_i,
                 (got_q.size() > 2) ? got_q[2].en_cyc : -1,
                 (ack_q.size() > 0) ? ack_q[0].cyc + 2 : -1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    int d;
    clear_logs();
    @(posedge clk);
    #1;
    r0_we = 1'b1; r0_addr = 24'h00ABCD; r0_wdata = 32'hCAFEF00D; r0_req = 1'b1;
    while (got_q.size() < 3 && waited < 400) begin
      @(negedge clk);
      #1;
      waited++;
    end
    n_chk++;
    if (got_q.size() < 3) $display("FAIL rst_mid_reach: got %0d frames, expected 3", got_q.size());
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    r0_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || eng_en !== 1'b0 || r0_ack !== 1'b0 || rdata !== 32'h0)
      $display("FAIL rst_mid_state: got busy=%0b eng_en=%0b ack=%0b rdata=%h, expected 0 0 0 0",
               busy, eng_en, r0_ack, rdata);
    else n_pass++;
    repeat (60) @(negedge clk);
    n_chk++;
    if (ack_q.size() != 0 || got_q.size() != 3)
      $display("FAIL rst_mid_quiet: got %0d acks %0d frames, expected 0 acks 3 frames",
               ack_q.size(), got_q.size());
    else n_pass++;
    wip_q.delete();
    rd_q.delete();
    model_rdata = 32'h0;
    clear_logs();
    model_read(0, 24'h00ABCD, $urandom);
    drive_req(0, 1'b0, 24'h00ABCD, 32'h0, 1);
    d = frame_diff();
    n_chk++;
    if (d != -1) show_frames("rst_mid_read", d); else n_pass++;
    d = ack_diff();
    n_chk++;
    if (d != -1) show_acks("rst_mid_read", d); else n_pass++;
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int d;
    clear_logs();
    model_write(0, 24'h123456, 32'h0BADF00D, POLL_MAX + 2);
    drive_req(0, 1'b1, 24'h123456, 32'h0BADF00D, 1);
    d = frame_diff();
    n_chk++;
    if (d != -1) show_frames("timeout_frames", d); else n_pass++;
    d = ack_diff();
    n_chk++;
    if (d != -1) show_acks("timeout_ack", d); else n_pass++;
    wip_q.delete();
  endtask
`endif

  task automatic test_back_to_back();
    int d;
    logic [23:0] a;
    clear_logs();
    a = 24'($urandom);
    for (int i = 0; i < 3; i++) model_read(0, a, $urandom);
    drive_req(0, 1'b0, a, 32'h0, 3);
    d = frame_diff();
    n_chk++;
    if (d != -1) show_frames("b2b_frames", d); else n_pass++;
    d = ack_diff();
    n_chk++;
    if (d != -1) show_acks("b2b_acks", d); else n_pass++;
    n_chk++;
    if (got_q.size() < 3 || ack_q.size() < 1 || got_q[2].en_cyc != ack_q[0].cyc + 2)
      $display("FAIL b2b_regrant: got eng_en at %0d, expected %0d",
               (got_q.size() > 2) ? got_q[2].en_cyc : -1, (ack_q.size() > 0) ? ack_q[0].cyc + 2 : -1);
    else n_pass++;
  endtask

  task automatic test_random();
    int d;
    int port, nb;
    logic we;
    logic [23:0] a;
    logic [31:0] wd;
    for (int it = 0; it < 8; it++) begin
      clear_logs();
      port = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      a    = 24'($urandom);
      wd   = $urandom;
      nb   = int'($urandom_range(0, 3));
      if (we) model_write(port, a, wd, nb);
      else model_read(port, a, $urandom);
      drive_req(port, we, a, wd, 1);
      d = frame_diff();
      n_chk++;
      if (d != -1) show_frames($sformatf("rand%0d", it), d); else n_pass++;
      d = ack_diff();
      n_chk++;
      if (d != -1) show_acks($sformatf("rand%0d", it), d); else n_pass++;
      n_chk++;
      if (ack_late_cnt() != 0) $display("FAIL rand%0d_timing: got %0d late acks, expected 0", it, ack_late_cnt());
      else n_pass++;
    end
  endtask

  task automatic test_engine_protocol();
    n_chk++;
    if (overlap_cnt != 0) $display("FAIL eng_overlap: got %0d overlapping eng_en, expected 0", overlap_cnt);
    else n_pass++;
    n_chk++;
    if (hold_bad != 0) $display("FAIL eng_hold_stable: got %0d unstable cycles, expected 0", hold_bad);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    eng_done = 1'b0;
    eng_dout = '0;
    model_rdata = 32'h0;
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_reset_mid();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    test_random();
    test_engine_protocol();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
